// File: rtl/alu_req_arbiter.sv
// Shares one combinational 6-bit ALU among NUM_REQ requesters using round-robin arbitration.
// The ALU result is registered together with the requester tag, and the consumer can apply
// backpressure. Define ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module alu_req_arbiter #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NUM_REQ-1:0]   i_req_valid,
   output logic [NUM_REQ-1:0]   o_req_ready,
   input  logic [6*NUM_REQ-1:0] i_req_a,
   input  logic [6*NUM_REQ-1:0] i_req_b,
   input  logic [2*NUM_REQ-1:0] i_req_op,
   output logic                 o_res_valid,
   input  logic                 i_res_ready,
   output logic [5:0]           o_res_data,
   output logic [ID_W-1:0]      o_res_id
);

   typedef enum logic {StEmpty, StFull} state_t;

   state_t          r_state, w_state_d;
   logic [5:0]      r_data, w_data_d;
   logic [ID_W-1:0] r_id, w_id_d;

   logic            w_can_accept, w_any, w_grant;
   logic [ID_W-1:0] w_winner;
   logic [5:0]      w_a, w_b, w_alu;
   logic [1:0]      w_op;

`ifndef ARB_FIXED_PRIO_EN
   logic [ID_W-1:0] r_last, w_last_d;
`endif

   assign w_can_accept = !i_rst && ((r_state == StEmpty) || i_res_ready);
   assign w_grant      = w_can_accept && w_any;

`ifdef ARB_FIXED_PRIO_EN
   always_comb begin
      w_any    = 1'b0;
      w_winner = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!w_any && i_req_valid[ID_W'(i)]) begin
            w_any    = 1'b1;
            w_winner = ID_W'(i);
         end
      end
   end
`else
   // Search starts just past the last winner and wraps modulo NUM_REQ.
   always_comb begin
      int unsigned v_idx;
      w_any    = 1'b0;
      w_winner = '0;
      v_idx    = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         v_idx = (32'(r_last) + k) % NUM_REQ;
         if (!w_any && i_req_valid[ID_W'(v_idx)]) begin
            w_any    = 1'b1;
            w_winner = ID_W'(v_idx);
         end
      end
   end
`endif

   always_comb begin
      o_req_ready = '0;
      if (w_grant) o_req_ready[w_winner] = 1'b1;
   end

   always_comb begin
      w_a  = '0;
      w_b  = '0;
      w_op = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (ID_W'(i) == w_winner) begin
            w_a  = i_req_a[6*i +: 6];
            w_b  = i_req_b[6*i +: 6];
            w_op = i_req_op[2*i +: 2];
         end
      end
   end

   // ALU: all results wrap modulo 64; |2A-B| is formed at 7 bits before truncation.
   always_comb begin
      w_alu = '0;
      unique case (w_op)
         2'b00: w_alu = (w_a << 2) + (w_b >> 1);
         2'b01: w_alu = w_a + w_b + (w_b << 1);
         2'b10: w_alu = 6'd0 - w_b;
         2'b11: w_alu = ({w_a, 1'b0} >= {1'b0, w_b}) ? 6'({w_a, 1'b0} - {1'b0, w_b})
                                                     : 6'({1'b0, w_b} - {w_a, 1'b0});
         default: w_alu = '0;
      endcase
   end

   always_comb begin
      w_state_d = r_state;
      w_data_d  = r_data;
      w_id_d    = r_id;
`ifndef ARB_FIXED_PRIO_EN
      w_last_d  = r_last;
`endif
      if (w_grant) begin
         w_state_d = StFull;
         w_data_d  = w_alu;
         w_id_d    = w_winner;
`ifndef ARB_FIXED_PRIO_EN
         w_last_d  = w_winner;
`endif
      end else if (r_state == StFull && i_res_ready) begin
         w_state_d = StEmpty;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StEmpty;
         r_data  <= '0;
         r_id    <= '0;
`ifndef ARB_FIXED_PRIO_EN
         r_last  <= ID_W'(NUM_REQ - 1);
`endif
      end else begin
         r_state <= w_state_d;
         r_data  <= w_data_d;
         r_id    <= w_id_d;
`ifndef ARB_FIXED_PRIO_EN
         r_last  <= w_last_d;
`endif
      end
   end

   assign o_res_valid = (r_state == StFull);
   assign o_res_data  = r_data;
   assign o_res_id    = r_id;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed steps followed by random traffic, checked against an
// arithmetic reference model of arbitration, handshake and ALU results.
module tb_alu_req_arbiter;
   localparam int N    = 4;
   localparam int ID_W = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid, req_ready, last_rdy;
   logic [6*N-1:0]  req_a, req_b;
   logic [2*N-1:0]  req_op;
   logic            res_valid, res_ready;
   logic [5:0]      res_data;
   logic [ID_W-1:0] res_id;

   logic [5:0] a_arr [N];
   logic [5:0] b_arr [N];
   logic [1:0] op_arr[N];

   int n_vec = 0;
   int n_err = 0;

   // Reference model state.
   int m_last, m_data, m_id;
   bit m_full;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_a[6*i +: 6]  = a_arr[i];
         req_b[6*i +: 6]  = b_arr[i];
         req_op[2*i +: 2] = op_arr[i];
      end
   end

   alu_req_arbiter #(.NUM_REQ(N)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .o_req_ready (req_ready),
      .i_req_a     (req_a),
      .i_req_b     (req_b),
      .i_req_op    (req_op),
      .o_res_valid (res_valid),
      .i_res_ready (res_ready),
      .o_res_data  (res_data),
      .o_res_id    (res_id)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int alu_ref(input int a, input int b, input int op);
      int d;
      case (op)
         0:       return (a * 4 + b / 2) % 64;
         1:       return (a + 3 * b) % 64;
         2:       return (64 - b) % 64;
         default: begin
            d = 2 * a - b;
            if (d < 0) d = -d;
            return d % 64;
         end
      endcase
   endfunction

   function automatic int pick(input logic [N-1:0] v);
`ifdef ARB_FIXED_PRIO_EN
      for (int i = 0; i < N; i++) if (v[i]) return i;
`else
      for (int k = 1; k <= N; k++) if (v[(m_last + k) % N]) return (m_last + k) % N;
`endif
      return -1;
   endfunction

   task automatic model_reset();
      m_last = N - 1;
      m_full = 0;
      m_data = 0;
      m_id   = 0;
   endtask

   // Inputs are set at a falling edge; one clock is applied and both sides are checked.
   task automatic step(input string tag);
      logic [N-1:0] exp_rdy;
      int w;
      #1;
      w = (rst || (m_full && !res_ready)) ? -1 : pick(req_valid);
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      last_rdy = req_ready;
      chk({tag, "_rdy"}, 32'(req_ready), 32'(exp_rdy));
      @(posedge clk);
      if (rst) model_reset();
      else if (w >= 0) begin
         m_data = alu_ref(a_arr[w], b_arr[w], op_arr[w]);
         m_id   = w;
         m_full = 1;
         m_last = w;
      end else if (m_full && res_ready) m_full = 0;
      #1;
      chk({tag, "_vld"}, 32'(res_valid), 32'(m_full));
      chk({tag, "_dat"}, 32'(res_data), 32'(m_data));
      chk({tag, "_id"}, 32'(res_id), 32'(m_id));
      @(negedge clk);
   endtask

   initial begin
      logic [5:0] held;
      model_reset();
      last_rdy  = '0;
      for (int i = 0; i < N; i++) begin
         a_arr[i] = 6'(i + 1); b_arr[i] = 6'(i + 2); op_arr[i] = 2'(i);
      end
      // Reset with every requester asking.
      rst = 1'b1; req_valid = '1; res_ready = 1'b1;
      step("t1"); step("t1");
      rst = 1'b0; req_valid = '0;
      #1;
      chk("t1_rel_vld", 32'(res_valid), 0);
      chk("t1_rel_dat", 32'(res_data), 0);
      chk("t1_rel_id", 32'(res_id), 0);

      // Single request, A+3B.
      req_valid = 4'b0001; a_arr[0] = 6'd5; b_arr[0] = 6'd3; op_arr[0] = 2'b01;
      step("t2");
      chk("t2_dat_const", 32'(res_data), 14);
      chk("t2_id_const", 32'(res_id), 0);

      // Rotation under full load after a fresh reset.
      rst = 1'b1; req_valid = '0; step("t3_rst"); rst = 1'b0;
      req_valid = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         step("t3");
`ifdef ARB_FIXED_PRIO_EN
         chk("t3_seq", 32'(res_id), 0);
`else
         chk("t3_seq", 32'(res_id), 32'(k % N));
`endif
      end

      // Opcode checks through requester 2.
      req_valid = 4'b0100;
      a_arr[2] = 6'd3; b_arr[2] = 6'd4; op_arr[2] = 2'b00; step("t4");
      chk("t4_op00", 32'(res_data), 14);
      a_arr[2] = 6'd0; b_arr[2] = 6'd1; op_arr[2] = 2'b10; step("t4");
      chk("t4_op10", 32'(res_data), 63);
      a_arr[2] = 6'd5; b_arr[2] = 6'd3; op_arr[2] = 2'b11; step("t4");
      chk("t4_op11", 32'(res_data), 7);
      chk("t4_id", 32'(res_id), 2);
      req_valid = '0; step("t4_drain");

      // Backpressure: fill, hold three cycles, then drain and accept together.
      res_ready = 1'b0; req_valid = 4'b0010;
      a_arr[1] = 6'd10; b_arr[1] = 6'd1; op_arr[1] = 2'b01; step("t5_fill");
      held = res_data;
      a_arr[1] = 6'd20; b_arr[1] = 6'd2; op_arr[1] = 2'b01;
      for (int k = 0; k < 3; k++) begin
         step("t5_hold");
         chk("t5_held", 32'(res_data), 32'(held));
      end
      res_ready = 1'b1; step("t5_go");
      chk("t5_new", 32'(res_data), 26);
      chk("t5_vld", 32'(res_valid), 1);

      // Reset discards a pending result and reinitialises the pointer.
      req_valid = 4'b1000; step("t6_acc");
      rst = 1'b1; req_valid = '0; step("t6_rst");
      chk("t6_vld0", 32'(res_valid), 0);
      rst = 1'b0; req_valid = 4'b1001; step("t6_first");
      chk("t6_id", 32'(res_id), 0);

      // Random traffic; operands change only when a request is not pending.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || last_rdy[i]) begin
               a_arr[i] = 6'($urandom); b_arr[i] = 6'($urandom); op_arr[i] = 2'($urandom);
            end
         end
         req_valid = 4'($urandom);
         res_ready = ($urandom_range(3) != 0);
         rst       = ($urandom_range(60) == 0);
         step("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
